// File: rtl/fetch_stage_if.sv
// Bundles the hazard-unit controls, redirect requests, instruction-memory port,
// IF/ID pipeline register outputs and performance counters of the fetch stage.
interface fetch_stage_if;
   logic        pcwrite_i;
   logic        ifid_write_i;
   logic        ifid_flush_i;
   logic        branch_i;
   logic [31:0] branch_target_i;
   logic        jump_i;
   logic [31:0] jump_target_i;
   logic [31:0] imem_instr_i;
   logic        imem_ready_i;
   logic [31:0] imem_addr_o;
   logic [31:0] ifid_instr_o;
   logic [31:0] ifid_pc4_o;
   logic        ifid_valid_o;
   logic [31:0] stall_cnt_o;
   logic [31:0] flush_cnt_o;

   modport slave (
      input  pcwrite_i, ifid_write_i, ifid_flush_i,
      input  branch_i, branch_target_i, jump_i, jump_target_i,
      input  imem_instr_i, imem_ready_i,
      output imem_addr_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o,
      output stall_cnt_o, flush_cnt_o
   );

   modport master (
      output pcwrite_i, ifid_write_i, ifid_flush_i,
      output branch_i, branch_target_i, jump_i, jump_target_i,
      output imem_instr_i, imem_ready_i,
      input  imem_addr_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o,
      input  stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID register and imem-wait/redirect FSM.
// Define FETCH_PERF_EN to build the saturating stall/flush performance counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk_i,
   input  logic         rst_i,
   fetch_stage_if.slave bus
);

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_WAIT_REDIR} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_q, pend_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_plus4;
   logic        load_fetch;
   logic        load_bubble;

   always_comb begin
      redirect    = bus.branch_i | bus.jump_i;
      target      = (bus.branch_i ? bus.branch_target_i : bus.jump_target_i) & ~32'h3;
      pc_plus4    = pc_q + 32'd4;
      state_d     = state_q;
      pc_d        = pc_q;
      pend_d      = pend_q;
      load_fetch  = 1'b0;
      load_bubble = 1'b0;

      unique case (state_q)
         S_RUN: begin
            if (bus.imem_ready_i) begin
               if (redirect)           pc_d = target;
               else if (bus.pcwrite_i) pc_d = pc_plus4;
               load_fetch = bus.ifid_write_i;
            end else begin
               load_bubble = bus.ifid_write_i;
               state_d     = redirect ? S_WAIT_REDIR : S_WAIT;
               if (redirect) pend_d = target;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               pend_d      = target;
               state_d     = S_WAIT_REDIR;
               load_bubble = bus.ifid_write_i;
            end else if (bus.imem_ready_i) begin
               if (bus.pcwrite_i) pc_d = pc_plus4;
               load_fetch = bus.ifid_write_i;
               state_d    = S_RUN;
            end else begin
               load_bubble = bus.ifid_write_i;
            end
         end
         S_WAIT_REDIR: begin
            // The returned instruction belongs to the abandoned path; newest target wins.
            if (redirect) pend_d = target;
            load_bubble = bus.ifid_write_i;
            if (bus.imem_ready_i) begin
               pc_d    = pend_d;
               state_d = S_RUN;
            end
         end
         default: state_d = S_RUN;
      endcase

      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (load_fetch) begin
         instr_d = bus.imem_instr_i;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
      end
      if (load_bubble || bus.ifid_flush_i) begin
         instr_d = '0;
         pc4_d   = '0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_RUN;
         pc_q    <= RESET_PC;
         pend_q  <= '0;
         instr_q <= '0;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign bus.imem_addr_o  = pc_q;
   assign bus.ifid_instr_o = instr_q;
   assign bus.ifid_pc4_o   = pc4_q;
   assign bus.ifid_valid_o = valid_q;

`ifdef FETCH_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (state_q != S_RUN && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
      if (bus.ifid_flush_i && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall_cnt_o = stall_cnt_q;
   assign bus.flush_cnt_o = flush_cnt_q;
`else
   assign bus.stall_cnt_o = '0;
   assign bus.flush_cnt_o = '0;
`endif

endmodule
